lfsr11_share_arb: RTL and testbench



---
 rtl/lfsr11_pkg.sv | 17 +
 rtl/lfsr11_rr_pick.sv | 32 +++
 rtl/lfsr11_share_arb.sv | 133 +++++++++++++
 tb/tb_lfsr11_share_arb.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr11_pkg.sv
// Shared types and the LFSR step for the 11-bit generator arbiter.
// Polynomial x^11 + x^9 + 1, shifting toward the MSB, feedback into bit 0.
package lfsr11_pkg;

    localparam int LFSR_W = 11;
    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 11'h7FF;

    typedef enum logic {
        IDLE,
        SERVE
    } arb_state_t;

    function automatic logic [LFSR_W-1:0] lfsr11_next(input logic [LFSR_W-1:0] q);
        return {q[9:0], q[8] ^ q[10]};
    endfunction

endpackage

// File: rtl/lfsr11_rr_pick.sv
// Circular priority picker: first asserted req at or after ptr.
// Latency: combinational. Backpressure: none, pure function of inputs.
// found is low when no request is asserted (idx is then 0).
module lfsr11_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] idx
);

    always_comb begin
        int j;
        logic [PTR_W-1:0] jj;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            jj = PTR_W'(j);
            if (!found && req[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
    end

endmodule

// File: rtl/lfsr11_share_arb.sv
// Round-robin sharing of one 11-bit LFSR; each grant returns the current word and steps it.
// Latency: req sampled at edge t -> gnt/rsp registered at edge t (visible the following cycle).
// Backpressure: requesters hold req level; bursts capped at MAX_BURST. LFSR_STATS_EN adds word_cnt/period_wrap.
module lfsr11_share_arb
    import lfsr11_pkg::*;
#(
    parameter int                NUM_REQ   = 4,
    parameter int                MAX_BURST = 4,
    parameter logic [LFSR_W-1:0] SEED_INIT = SEED_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rsp_valid,
    output logic [LFSR_W-1:0]  rsp_data,
    input  logic               seed_load,
    input  logic [LFSR_W-1:0]  seed_value,
    output logic               seed_err,
    output logic               busy
`ifdef LFSR_STATS_EN
    ,
    output logic [15:0]        word_cnt,
    output logic               period_wrap
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    arb_state_t        state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  owner;
    logic [PTR_W-1:0]  owner_inc;
    logic [PTR_W-1:0]  pick_ptr;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_found;
    logic [3:0]        burst_cnt;
    logic [LFSR_W-1:0] lfsr_q;
    logic              cont;
    logic              deliver;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    assign owner_inc = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    // While serving, any re-pick is a handoff and starts just past the owner.
    assign pick_ptr  = (state == SERVE) ? owner_inc : rr_ptr;
    assign cont      = (state == SERVE) && req[owner] && (burst_cnt < BURST_MAX);
    assign deliver   = !seed_load && (cont || pick_found);

    lfsr11_rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            lfsr_q    <= SEED_INIT;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            seed_err  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            seed_err <= 1'b0;
            if (seed_load) begin
                if (seed_value != '0) lfsr_q <= seed_value;
                else                  seed_err <= 1'b1;
                if (state == SERVE) rr_ptr <= owner_inc;
                state     <= IDLE;
                busy      <= 1'b0;
                gnt       <= '0;
                rsp_valid <= 1'b0;
            end else if (cont) begin
                burst_cnt <= burst_cnt + 1'b1;
                gnt       <= onehot(owner);
                rsp_valid <= 1'b1;
            end else begin
                if (state == SERVE) rr_ptr <= owner_inc;
                if (pick_found) begin
                    owner     <= pick_idx;
                    burst_cnt <= 4'd1;
                    state     <= SERVE;
                    busy      <= 1'b1;
                    gnt       <= onehot(pick_idx);
                    rsp_valid <= 1'b1;
                end else begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    gnt       <= '0;
                    rsp_valid <= 1'b0;
                end
            end
            if (deliver) begin
                rsp_data <= lfsr_q;
                lfsr_q   <= lfsr11_next(lfsr_q);
            end
        end
    end

`ifdef LFSR_STATS_EN
    logic [LFSR_W-1:0] last_seed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt    <= '0;
            period_wrap <= 1'b0;
            last_seed   <= SEED_INIT;
        end else begin
            period_wrap <= deliver && (lfsr11_next(lfsr_q) == last_seed);
            if (seed_load && (seed_value != '0)) begin
                word_cnt  <= '0;
                last_seed <= seed_value;
            end else if (deliver && (word_cnt != 16'hFFFF)) begin
                word_cnt <= word_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lfsr11_share_arb.sv
// Self-checking bench for lfsr11_share_arb: directed scenarios plus a randomized run
// against a cycle-level reference model of the arbitration and LFSR rules.
module tb_lfsr11_share_arb;

    localparam int N    = 4;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  gnt;
    logic          rsp_valid;
    logic [10:0]   rsp_data;
    logic          seed_load = 1'b0;
    logic [10:0]   seed_value = '0;
    logic          seed_err;
    logic          busy;
`ifdef LFSR_STATS_EN
    logic [15:0]   word_cnt;
    logic          period_wrap;
`endif

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [10:0] m_lfsr;
    int          m_owner;
    int          m_used;
    int          m_ptr;
    logic [N-1:0] e_gnt;
    logic        e_valid;
    logic [10:0] e_data;
    logic        e_err;
    logic        e_busy;

    always #5 clk = ~clk;

    lfsr11_share_arb #(
        .NUM_REQ   (N),
        .MAX_BURST (MAXB),
        .SEED_INIT (11'h7FF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .seed_err   (seed_err),
        .busy       (busy)
`ifdef LFSR_STATS_EN
        ,
        .word_cnt   (word_cnt),
        .period_wrap(period_wrap)
`endif
    );

    function automatic logic [10:0] ref_next(input logic [10:0] v);
        int x;
        x = int'(v);
        return 11'(((x * 2) & 2047) | (((x >> 8) ^ (x >> 10)) & 1));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req       = '0;
        seed_load = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic sl, input logic [10:0] sv);
        bit hit;
        e_err = 1'b0;
        if (sl) begin
            if (sv != 0) m_lfsr = sv;
            else         e_err = 1'b1;
            if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
            m_owner = -1;
        end else if (m_owner >= 0 && r[m_owner] && m_used < MAXB) begin
            m_used++;
        end else begin
            if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
            m_owner = -1;
            hit = 0;
            for (int k = 0; k < N; k++) begin
                if (!hit && r[(m_ptr + k) % N]) begin
                    hit     = 1;
                    m_owner = (m_ptr + k) % N;
                end
            end
            m_used = 1;
        end
        if (!sl && m_owner >= 0) begin
            e_gnt   = N'(1) << m_owner;
            e_valid = 1'b1;
            e_data  = m_lfsr;
            m_lfsr  = ref_next(m_lfsr);
        end else begin
            e_gnt   = '0;
            e_valid = 1'b0;
        end
        e_busy = (m_owner >= 0);
    endtask

    task automatic test_reset;
        #2;
        n_vec++; if (gnt !== '0)       begin n_err++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
        n_vec++; if (rsp_data !== '0)  begin n_err++; $display("FAIL reset_data got=%h exp=0", rsp_data); end
        n_vec++; if (seed_err !== 1'b0) begin n_err++; $display("FAIL reset_seed_err got=%b exp=0", seed_err); end
        n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        req = 4'b0001;
        tick();
        req = '0;
        n_vec++; if (gnt !== 4'b0001)  begin n_err++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        n_vec++; if (rsp_data !== 11'h7FF) begin n_err++; $display("FAIL single_data got=%h exp=7ff", rsp_data); end
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
        n_vec++; if (busy !== 1'b1)    begin n_err++; $display("FAIL single_busy got=%b exp=1", busy); end
        tick();
        n_vec++; if (gnt !== '0)       begin n_err++; $display("FAIL single_end_gnt got=%b exp=0", gnt); end
        n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL single_end_busy got=%b exp=0", busy); end
    endtask

    task automatic test_burst;
        logic [10:0] exp_d [9];
        logic [3:0]  exp_g [9];
        exp_d = '{11'h7FF, 11'h7FE, 11'h7FC, 11'h7F8, 11'h7F0, 11'h7E0, 11'h7C0, 11'h780, 11'h700};
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
        do_reset();
        req = 4'b0101;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_vec++; if (gnt !== exp_g[i]) begin n_err++; $display("FAIL burst_gnt word=%0d got=%b exp=%b", i, gnt, exp_g[i]); end
            n_vec++; if (rsp_data !== exp_d[i]) begin n_err++; $display("FAIL burst_data word=%0d got=%h exp=%h", i, rsp_data, exp_d[i]); end
            n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL burst_valid word=%0d got=%b exp=1", i, rsp_valid); end
        end
        req = '0;
        tick();
        n_vec++; if (gnt !== '0) begin n_err++; $display("FAIL burst_end_gnt got=%b exp=0", gnt); end
    endtask

    task automatic test_seed_one;
        seed_load  = 1'b1;
        seed_value = 11'h001;
        tick();
        seed_load = 1'b0;
        n_vec++; if (seed_err !== 1'b0) begin n_err++; $display("FAIL seed1_err got=%b exp=0", seed_err); end
        n_vec++; if (gnt !== '0) begin n_err++; $display("FAIL seed1_gnt got=%b exp=0", gnt); end
        req = 4'b0001;
        tick();
        n_vec++; if (rsp_data !== 11'h001) begin n_err++; $display("FAIL seed1_word0 got=%h exp=001", rsp_data); end
        tick();
        req = '0;
        n_vec++; if (rsp_data !== 11'h002) begin n_err++; $display("FAIL seed1_word1 got=%h exp=002", rsp_data); end
        n_vec++; if (seed_err !== 1'b0) begin n_err++; $display("FAIL seed1_err_late got=%b exp=0", seed_err); end
        tick();
    endtask

    task automatic test_seed_zero;
        seed_load  = 1'b1;
        seed_value = 11'h000;
        tick();
        seed_load = 1'b0;
        n_vec++; if (seed_err !== 1'b1) begin n_err++; $display("FAIL seed0_err got=%b exp=1", seed_err); end
        n_vec++; if (gnt !== '0) begin n_err++; $display("FAIL seed0_gnt got=%b exp=0", gnt); end
        req = 4'b0001;
        tick();
        req = '0;
        n_vec++; if (seed_err !== 1'b0) begin n_err++; $display("FAIL seed0_err_clear got=%b exp=0", seed_err); end
        n_vec++; if (rsp_data !== 11'h004) begin n_err++; $display("FAIL seed0_word got=%h exp=004", rsp_data); end
        tick();
    endtask

    task automatic test_seed_midburst;
        logic [10:0] d;
        do_reset();
        req = 4'b0011;
        tick();
        tick();
        n_vec++; if (gnt !== 4'b0001 || rsp_data !== 11'h7FE) begin n_err++; $display("FAIL mid_second got=%b/%h exp=0001/7fe", gnt, rsp_data); end
        seed_load  = 1'b1;
        seed_value = 11'h123;
        tick();
        seed_load = 1'b0;
        n_vec++; if (gnt !== '0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_gap got=%b/%b exp=0000/0", gnt, rsp_valid); end
        d = 11'h123;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (gnt !== 4'b0010 || rsp_data !== d) begin n_err++; $display("FAIL mid_fresh word=%0d got=%b/%h exp=0010/%h", i, gnt, rsp_data, d); end
            d = ref_next(d);
        end
        tick();
        n_vec++; if (gnt !== 4'b0001 || rsp_data !== d) begin n_err++; $display("FAIL mid_rotate got=%b/%h exp=0001/%h", gnt, rsp_data, d); end
        req = '0;
        tick();
    endtask

    task automatic test_async_reset;
        do_reset();
        req = 4'b0001;
        tick();
        n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL arst_pre got=%b exp=0001", gnt); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (gnt !== '0) begin n_err++; $display("FAIL arst_gnt got=%b exp=0", gnt); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got=%b exp=0", rsp_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got=%b exp=0", busy); end
        rst_n = 1'b1;
        tick();
        req = '0;
        n_vec++; if (gnt !== 4'b0001 || rsp_data !== 11'h7FF) begin n_err++; $display("FAIL arst_restart got=%b/%h exp=0001/7ff", gnt, rsp_data); end
        tick();
    endtask

    task automatic test_random;
        do_reset();
        m_lfsr  = 11'h7FF;
        m_owner = -1;
        m_used  = 0;
        m_ptr   = 0;
        e_data  = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            seed_load  = ($urandom_range(0, 19) == 0);
            seed_value = ($urandom_range(0, 3) == 0) ? 11'h000 : 11'($urandom_range(1, 2047));
            model_step(req, seed_load, seed_value);
            tick();
            n_vec++; if (gnt !== e_gnt) begin n_err++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, gnt, e_gnt); end
            n_vec++; if (rsp_valid !== e_valid) begin n_err++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, rsp_valid, e_valid); end
            n_vec++; if (seed_err !== e_err) begin n_err++; $display("FAIL rnd_seed_err cyc=%0d got=%b exp=%b", c, seed_err, e_err); end
            n_vec++; if (busy !== e_busy) begin n_err++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, e_busy); end
            if (e_valid) begin
                n_vec++; if (rsp_data !== e_data) begin n_err++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, rsp_data, e_data); end
            end
        end
        req       = '0;
        seed_load = 1'b0;
        tick();
    endtask

`ifdef LFSR_STATS_EN
    task automatic test_stats;
        int early;
        early = 0;
        do_reset();
        req = 4'b0001;
        for (int w = 1; w <= 2047; w++) begin
            tick();
            if (w < 2047 && period_wrap === 1'b1) early++;
        end
        req = '0;
        n_vec++; if (early != 0) begin n_err++; $display("FAIL stats_early_wrap got=%0d exp=0", early); end
        n_vec++; if (period_wrap !== 1'b1) begin n_err++; $display("FAIL stats_wrap got=%b exp=1", period_wrap); end
        n_vec++; if (word_cnt !== 16'd2047) begin n_err++; $display("FAIL stats_cnt got=%0d exp=2047", word_cnt); end
        tick();
        seed_load  = 1'b1;
        seed_value = 11'h055;
        tick();
        seed_load = 1'b0;
        n_vec++; if (word_cnt !== 16'd0) begin n_err++; $display("FAIL stats_clear got=%0d exp=0", word_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_seed_one();
        test_seed_zero();
        test_seed_midburst();
        test_async_reset();
        test_random();
`ifdef LFSR_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
